// File: rtl/adder_resp_checker.sv
// Exhaustive response checker for a WIDTH-bit adder; latency (SETTLE_CYCLES+1) cycles per vector, done one edge after the last check.
// No backpressure: start is accepted only in IDLE/DONE; optional ADDER_RESP_CHECKER_STOP_ON_FAIL_EN ends the sweep at the first mismatch.
module adder_resp_checker #(
    parameter int WIDTH         = 3,
    parameter int SETTLE_CYCLES = 2,
    parameter int ERR_CNT_W     = 8
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   start,
    output logic [WIDTH-1:0]       dut_a,
    output logic [WIDTH-1:0]       dut_b,
    output logic                   dut_c0,
    input  logic [WIDTH-1:0]       dut_sum,
    input  logic                   dut_cout,
    output logic                   busy,
    output logic                   done,
    output logic                   pass,
    output logic [ERR_CNT_W-1:0]   err_count,
    output logic                   fail_valid,
    output logic [2*WIDTH:0]       fail_vec
);

    localparam int VW = 2*WIDTH + 1;
    localparam logic [7:0] SETTLE_LAST = 8'(SETTLE_CYCLES - 1);

    typedef enum logic [1:0] {IDLE, SETTLE, CHECK, DONE} state_t;

    state_t          state;
    logic [VW-1:0]   vec;
    logic [7:0]      settle_cnt;
    logic [WIDTH:0]  expected;
    logic [WIDTH:0]  observed;
    logic            mismatch;
    logic            last_vec;
    logic            finish_sweep;

    // The DUT operands are the vector register itself, so they are glitch-free.
    assign dut_a  = vec[VW-1 -: WIDTH];
    assign dut_b  = vec[WIDTH:1];
    assign dut_c0 = vec[0];

    always_comb begin
        expected = {1'b0, dut_a} + {1'b0, dut_b} + {{WIDTH{1'b0}}, dut_c0};
        observed = {dut_cout, dut_sum};
        mismatch = (expected != observed);
        last_vec = &vec;
`ifdef ADDER_RESP_CHECKER_STOP_ON_FAIL_EN
        finish_sweep = last_vec || mismatch;
`else
        finish_sweep = last_vec;
`endif
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state      <= IDLE;
            vec        <= '0;
            settle_cnt <= '0;
            err_count  <= '0;
            fail_vec   <= '0;
            fail_valid <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
            pass       <= 1'b0;
        end else begin
            case (state)
                IDLE, DONE: begin
                    if (start) begin
                        vec        <= '0;
                        settle_cnt <= '0;
                        err_count  <= '0;
                        fail_vec   <= '0;
                        fail_valid <= 1'b0;
                        busy       <= 1'b1;
                        done       <= 1'b0;
                        pass       <= 1'b0;
                        state      <= SETTLE;
                    end else if (state == DONE) begin
                        // Status lags DONE entry by one edge so err_count is final.
                        done <= 1'b1;
                        pass <= (err_count == '0);
                    end
                end
                SETTLE: begin
                    settle_cnt <= settle_cnt + 8'd1;
                    if (settle_cnt == SETTLE_LAST)
                        state <= CHECK;
                end
                CHECK: begin
                    if (mismatch) begin
                        if (!(&err_count))
                            err_count <= err_count + 1'b1;
                        if (!fail_valid) begin
                            fail_vec   <= vec;
                            fail_valid <= 1'b1;
                        end
                    end
                    if (finish_sweep) begin
                        busy  <= 1'b0;
                        state <= DONE;
                    end else begin
                        vec        <= vec + 1'b1;
                        settle_cnt <= '0;
                        state      <= SETTLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: doc/adder_resp_checker.md
Name: adder_resp_checker

Overview:
- Synthesizable response-side companion to the 3-bit adder family (rtl, CLA gate-level, RCA gate-level).
- On start, sweeps every {a, b, c0} vector into an adder DUT, waits a settle window, and compares the DUT {cout, sum} against a + b + c0.
- Accumulates a mismatch count, captures the first failing vector, and reports pass/fail.
- Sits between the adder DUTs and the board LEDs/simulation top, replacing hand-inspection of $monitor output.

Parameters:
- WIDTH, 3, operand width of a, b and sum.
- SETTLE_CYCLES, 2, clock cycles the vector is held before comparison; legal range 1..255.
- ERR_CNT_W, 8, width of the saturating mismatch counter.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  synchronous active-low reset.
- start  input  1  begin a sweep; sampled in IDLE or DONE only.
- dut_a  output  WIDTH  operand a driven to DUT.
- dut_b  output  WIDTH  operand b driven to DUT.
- dut_c0  output  1  carry-in driven to DUT.
- dut_sum  input  WIDTH  DUT sum.
- dut_cout  input  1  DUT carry-out.
- busy  output  1  high from the cycle after an accepted start until DONE is entered.
- done  output  1  level; high while in DONE.
- pass  output  1  done && err_count == 0.
- err_count  output  ERR_CNT_W  saturating mismatch count.
- fail_valid  output  1  a first failure has been captured.
- fail_vec  output  2*WIDTH+1  first failing {a, b, c0}.

Behaviour:
- Vector counter vec is 2*WIDTH+1 bits. {dut_a, dut_b, dut_c0} = vec, registered.
- Expected value is WIDTH+1 bits: {1'b0,a} + {1'b0,b} + c0, compared with {dut_cout, dut_sum}.
- States: IDLE, SETTLE, CHECK, DONE.
- Reset (rst_n low at a clk edge):
  - State goes to IDLE.
  - vec, err_count, fail_vec, fail_valid, busy, done, pass and all dut_* outputs are cleared to 0.
  - Reset applied mid-sweep aborts the sweep immediately; there is no partial result.
- IDLE or DONE, start=1:
  - Next edge: vec<=0, err_count<=0, fail_valid<=0, fail_vec<=0, settle counter<=0.
  - State goes to SETTLE; busy=1, done=0.
- SETTLE:
  - The settle counter increments each cycle.
  - After SETTLE_CYCLES cycles in SETTLE, state goes to CHECK.
- CHECK (exactly one cycle) compares expected against DUT.
  - On mismatch, err_count increments, saturating at all-ones.
  - On mismatch with fail_valid=0, fail_vec<=vec and fail_valid<=1. Later mismatches never overwrite fail_vec.
  - If vec is all-ones, state goes to DONE; vec holds and does not wrap.
  - Otherwise vec<=vec+1, the settle counter is cleared, and state goes to SETTLE.
- Latency: each vector takes SETTLE_CYCLES+1 cycles. With defaults, done rises 1 + 128*3 = 385 edges after the start edge.
- start while busy is ignored and has no effect on the sweep.
- DONE holds all results until the next start or reset.
- dut_* hold the last vector in DONE.

Optional Feature:
- Macro: ADDER_RESP_CHECKER_STOP_ON_FAIL_EN.
- Defined: a mismatch in CHECK moves the state to DONE in the same transition. err_count=1, fail_vec is captured, and vec holds the failing vector.
- Undefined: the full sweep always completes as described above.

Test Plan:
- Correct adder_rtl DUT, start pulse, defaults -> done=1 after 385 edges; err_count=0; pass=1; fail_valid=0; final dut_a=7, dut_b=7, dut_c0=1.
- DUT with sum[0] stuck at 0 -> err_count=64, fail_vec=7'b0000001, fail_valid=1, pass=0.
- DUT with cout stuck at 0 -> fail_vec=7'b0001111 (a=0, b=7, c0=1); pass=0.
- Same stuck-sum[0] DUT with ERR_CNT_W=4 -> err_count saturates at 15 with no wrap.
- Reset and start rules:
  - rst_n low for one edge at cycle 100 of a sweep -> next edge all outputs 0 and state IDLE.
  - A later start runs a full clean sweep.
  - A second start pulse mid-sweep changes nothing.
- STOP_ON_FAIL_EN defined with stuck sum[0] -> done after vector 1 check (7 edges after start); err_count=1; fail_vec=7'b0000001.
